muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencer between the CPU control unit and the shared multi-cycle Mult and Div datapaths. It accepts one HI/LO-class operation at a time (MULT, DIV, MTHI, MTLO) and launches the selected unit with a one-cycle start pulse. It waits for that unit's stop flag, then commits the results into the architectural HI/LO registers. It asserts Busy to stall the pipeline and flags divide-by-zero and watchdog timeouts.

Parameters:
TIMEOUT, 40, maximum number of WAIT cycles before an operation is abandoned (must be greater than the worst-case unit latency of 33 cycles).
CNT_W, 6, width of the WAIT cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
OpValid  input  1  operation request from control unit
OpCode  input  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
RsVal  input  32  operand A / MTHI-MTLO source
RtVal  input  32  operand B
Ready  output  1  controller accepts a request this cycle
Busy  output  1  pipeline stall; equals ~Ready
MultStart  output  1  one-cycle start pulse to Mult
DivStart  output  1  one-cycle start pulse to Div
OpA  output  32  latched operand A, shared by both units
OpB  output  32  latched operand B, shared by both units
MultStop  input  1  Mult completion flag
MultHi  input  32  Mult high result
MultLo  input  32  Mult low result
DivStop  input  1  Div completion flag
DivHi  input  32  Div remainder
DivLo  input  32  Div quotient
HI  output  32  architectural HI register
LO  output  32  architectural LO register
Done  output  1  one-cycle pulse when an operation commits
DivZero  output  1  one-cycle pulse: DIV with RtVal==0 rejected
Timeout  output  1  one-cycle pulse: watchdog expired

Behaviour:
- Reset state: IDLE. HI, LO, OpA and OpB are 0. MultStart, DivStart, Done, DivZero and Timeout are 0. Ready is 1 and Busy is 0. The counter is 0.
- Reset has priority over all other inputs, including mid-operation. A unit in flight is abandoned and its later Stop is ignored, because the controller is in IDLE.
- State machine: IDLE, LAUNCH, WAIT, COMMIT, ERR.
- IDLE: Ready=1. On the edge where OpValid=1:
  - Latch OpCode, RsVal into OpA and RtVal into OpB.
  - MULT goes to LAUNCH.
  - DIV with RtVal!=0 goes to LAUNCH.
  - DIV with RtVal==0 goes to ERR.
  - MTHI writes HI<=RsVal and goes to COMMIT.
  - MTLO writes LO<=RsVal and goes to COMMIT.
  - With OpValid=0, stay in IDLE.
- Ready=0 in every state except IDLE. Requests outside IDLE are ignored and are not queued.
- LAUNCH: asserts exactly one of MultStart or DivStart for one cycle, selected by the latched op. Clears the counter. Next state is WAIT.
- OpA and OpB are held stable from the accept edge until the controller returns to IDLE.
- WAIT:
  - Only the Stop of the selected unit is sampled; the other unit's Stop is ignored.
  - Counter increments each cycle.
  - Selected Stop=1: HI<=unit Hi and LO<=unit Lo at that edge, then go to COMMIT.
  - Otherwise, when counter == TIMEOUT-1: Timeout=1 for the next cycle, HI and LO unchanged, go to IDLE.
  - If Stop and the timeout condition occur on the same edge, Stop wins and the result commits.
- COMMIT: Done=1 for one cycle, then go to IDLE. New HI/LO values are visible in the COMMIT cycle.
- ERR: DivZero=1 for one cycle, HI and LO unchanged, Done=0, then go to IDLE.
- Latency, accept edge to Done high:
  - MTHI/MTLO: 1 cycle.
  - MULT/DIV: 2 + unit latency cycles.
  - Back-to-back requests: the next request can be accepted in the first IDLE cycle after Done.
- Done, DivZero and Timeout are mutually exclusive. Each is registered and each is a single-cycle pulse.

Test Plan:
- MULT: RsVal=7, RtVal=0xFFFFFFFD (-3); Mult stub raises MultStop 32 cycles after MultStart -> MultStart high for exactly 1 cycle, HI=0xFFFFFFFF, LO=0xFFFFFFEB, Done pulses once, Busy high from the cycle after accept until IDLE.
- DIV by zero: OpCode=01, RtVal=0 -> DivStart never asserted, DivZero pulses 1 cycle, HI/LO keep prior values (e.g. 0x12345678/0x9ABCDEF0), Ready=1 two cycles after accept.
- MTHI 0xCAFEBABE followed by MTLO 0x0000BEEF, back-to-back -> HI=0xCAFEBABE, LO=0x0000BEEF, two Done pulses 2 cycles apart.
- Timeout: MULT issued with MultStop held 0 -> Timeout pulses after 40 WAIT cycles, HI/LO unchanged, Ready=1 the following cycle; DivStop toggled during WAIT -> no effect.
- Reset mid-operation: Reset asserted at WAIT cycle 10 of a DIV -> next cycle HI=LO=0, Ready=1, no pulse outputs; DivStop arriving later -> ignored.
- Request while busy: OpValid held high with new operands during WAIT -> OpA/OpB unchanged, only one Done.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: issues one HI/LO-class operation at a time to the shared Mult/Div
// datapaths, waits for the selected unit and commits results into HI/LO.

module muldiv_ctrl_chk (
    input logic Clock,
    input logic Reset,
    input logic Ready,
    input logic Busy,
    input logic MultStart,
    input logic DivStart,
    input logic Done,
    input logic DivZero,
    input logic Timeout
);

    a_busy_inv: assert property (@(posedge Clock) disable iff (Reset) Busy == !Ready);
    a_start_excl: assert property (@(posedge Clock) disable iff (Reset) !(MultStart && DivStart));
    a_pulse_excl: assert property (@(posedge Clock) disable iff (Reset)
        $onehot0({Done, DivZero, Timeout}));
    a_mstart_one: assert property (@(posedge Clock) disable iff (Reset) MultStart |=> !MultStart);
    a_dstart_one: assert property (@(posedge Clock) disable iff (Reset) DivStart |=> !DivStart);

endmodule

module muldiv_ctrl #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        OpValid,
    input  logic [1:0]  OpCode,
    input  logic [31:0] RsVal,
    input  logic [31:0] RtVal,
    output logic        Ready,
    output logic        Busy,
    output logic        MultStart,
    output logic        DivStart,
    output logic [31:0] OpA,
    output logic [31:0] OpB,
    input  logic        MultStop,
    input  logic [31:0] MultHi,
    input  logic [31:0] MultLo,
    input  logic        DivStop,
    input  logic [31:0] DivHi,
    input  logic [31:0] DivLo,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Done,
    output logic        DivZero,
    output logic        Timeout
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             mult_start_q, mult_start_d;
    logic             div_start_q, div_start_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic             timeout_q, timeout_d;

    logic             sel_stop_s;
    logic [31:0]      sel_hi_s;
    logic [31:0]      sel_lo_s;

    // Route only the launched unit's completion flag and results into the WAIT logic.
    always_comb begin
        if (op_q == OP_MULT) begin
            sel_stop_s = MultStop;
            sel_hi_s   = MultHi;
            sel_lo_s   = MultLo;
        end else begin
            sel_stop_s = DivStop;
            sel_hi_s   = DivHi;
            sel_lo_s   = DivLo;
        end
    end

    // Next-state, datapath and pulse computation; pulses are raised on the edge
    // entering the state that owns them so they appear registered.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        cnt_d        = cnt_q;
        mult_start_d = 1'b0;
        div_start_d  = 1'b0;
        done_d       = 1'b0;
        div_zero_d   = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (OpValid) begin
                    op_d  = OpCode;
                    opa_d = RsVal;
                    opb_d = RtVal;
                    case (OpCode)
                        OP_MULT: begin
                            state_d      = ST_LAUNCH;
                            mult_start_d = 1'b1;
                        end
                        OP_DIV: begin
                            if (RtVal != 32'd0) begin
                                state_d     = ST_LAUNCH;
                                div_start_d = 1'b1;
                            end else begin
                                state_d    = ST_ERR;
                                div_zero_d = 1'b1;
                            end
                        end
                        OP_MTHI: begin
                            hi_d    = RsVal;
                            state_d = ST_COMMIT;
                            done_d  = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d    = RsVal;
                            state_d = ST_COMMIT;
                            done_d  = 1'b1;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                // A stop landing on the final watchdog cycle still commits.
                if (sel_stop_s) begin
                    hi_d    = sel_hi_s;
                    lo_d    = sel_lo_s;
                    state_d = ST_COMMIT;
                    done_d  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is registered from the next state so it is valid from the edge on.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
    end

    // State and architectural register update with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'b00;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            cnt_q        <= CNT_ZERO;
            ready_q      <= 1'b1;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            done_q       <= 1'b0;
            div_zero_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            done_q       <= done_d;
            div_zero_q   <= div_zero_d;
            timeout_q    <= timeout_d;
        end
    end

    assign Ready     = ready_q;
    assign Busy      = ~ready_q;
    assign MultStart = mult_start_q;
    assign DivStart  = div_start_q;
    assign OpA       = opa_q;
    assign OpB       = opb_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign Done      = done_q;
    assign DivZero   = div_zero_q;
    assign Timeout   = timeout_q;

    muldiv_ctrl_chk u_chk (
        .Clock     (Clock),
        .Reset     (Reset),
        .Ready     (ready_q),
        .Busy      (Busy),
        .MultStart (mult_start_q),
        .DivStart  (div_start_q),
        .Done      (done_q),
        .DivZero   (div_zero_q),
        .Timeout   (timeout_q)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: randomized ops against a cycle-level reference
// model, with behavioural Mult/Div stand-ins driven from the latched operands.

module tb_muldiv_ctrl;

    localparam int TIMEOUT = 40;
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;
    localparam logic [2:0] K_DONE = 3'b001;
    localparam logic [2:0] K_DZ   = 3'b010;
    localparam logic [2:0] K_TO   = 3'b100;

    logic Clock = 1'b0;
    logic Reset, OpValid;
    logic [1:0] OpCode;
    logic [31:0] RsVal, RtVal;
    logic Ready, Busy, MultStart, DivStart, Done, DivZero, Timeout;
    logic [31:0] OpA, OpB, HI, LO;
    logic MultStop, DivStop;
    logic [31:0] MultHi, MultLo, DivHi, DivLo;

    muldiv_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
        .Clock(Clock), .Reset(Reset), .OpValid(OpValid), .OpCode(OpCode),
        .RsVal(RsVal), .RtVal(RtVal), .Ready(Ready), .Busy(Busy),
        .MultStart(MultStart), .DivStart(DivStart), .OpA(OpA), .OpB(OpB),
        .MultStop(MultStop), .MultHi(MultHi), .MultLo(MultLo),
        .DivStop(DivStop), .DivHi(DivHi), .DivLo(DivLo),
        .HI(HI), .LO(LO), .Done(Done), .DivZero(DivZero), .Timeout(Timeout)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        int          mst;
        int          dst;
    } exp_t;

    exp_t sbq[$];
    int n_vec = 0, n_err = 0;
    bit mon_en = 1'b0, noise_en = 1'b0;
    int busy_lo = 0, busy_hi = 0;
    logic [31:0] cur_hi = 32'd0, cur_lo = 32'd0, cur_a = 32'd0, cur_b = 32'd0;
    logic [31:0] mdl_hi = 32'd0, mdl_lo = 32'd0;
    int exp_mst = 0, exp_dst = 0, mst_seen = 0, dst_seen = 0;
    int m_lat = 0, d_lat = 0;

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Returns {remainder, quotient}.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Mult stand-in: Stop rises lat edges after the edge that samples MultStart.
    bit m_pend = 1'b0;
    int m_fire = 0;
    logic [63:0] m_res = 64'd0;
    initial begin
        MultStop = 1'b0; MultHi = 32'd0; MultLo = 32'd0;
        forever begin
            @(negedge Clock);
            if (MultStart === 1'b1) begin
                m_pend = 1'b1; m_fire = cyc + 1 + m_lat; m_res = mul64(OpA, OpB);
            end
            if (m_pend && cyc == m_fire) begin
                MultStop = 1'b1; {MultHi, MultLo} = m_res; m_pend = 1'b0;
            end else begin
                MultStop = !m_pend && noise_en && ($urandom_range(0, 1) == 1);
                MultHi = $urandom; MultLo = $urandom;
            end
        end
    end

    // Div stand-in, same timing convention.
    bit d_pend = 1'b0;
    int d_fire = 0;
    logic [63:0] d_res = 64'd0;
    initial begin
        DivStop = 1'b0; DivHi = 32'd0; DivLo = 32'd0;
        forever begin
            @(negedge Clock);
            if (DivStart === 1'b1) begin
                d_pend = 1'b1; d_fire = cyc + 1 + d_lat; d_res = div64(OpA, OpB);
            end
            if (d_pend && cyc == d_fire) begin
                DivStop = 1'b1; {DivHi, DivLo} = d_res; d_pend = 1'b0;
            end else begin
                DivStop = !d_pend && noise_en && ($urandom_range(0, 1) == 1);
                DivHi = $urandom; DivLo = $urandom;
            end
        end
    end

    // Monitor: per-cycle invariants plus scoreboard pops on every result pulse.
    initial begin
        exp_t e;
        logic [2:0] ev;
        forever begin
            @(posedge Clock);
            #1;
            if (mon_en) begin
                if (MultStart === 1'b1) mst_seen++;
                if (DivStart === 1'b1) dst_seen++;
                chk("busy_vs_ready", Busy, !Ready);
                chk("ready", Ready, !(cyc >= busy_lo && cyc < busy_hi));
                ev = {Timeout, DivZero, Done};
                if (ev != 3'b000) begin
                    if (sbq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_pulse: got %b expected none at cycle %0d", ev, cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("pulse_kind", ev, e.kind);
                        chk("pulse_cycle", cyc, e.cyc);
                        chk("mult_starts", mst_seen, e.mst);
                        chk("div_starts", dst_seen, e.dst);
                        cur_hi = e.hi; cur_lo = e.lo;
                    end
                end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                    e = sbq.pop_front();
                    n_vec++; n_err++;
                    $display("FAIL pulse_missing: got none expected %b at cycle %0d", e.kind, e.cyc);
                    cur_hi = e.hi; cur_lo = e.lo;
                end
                chk("hi_reg", HI, cur_hi);
                chk("lo_reg", LO, cur_lo);
                if (Busy === 1'b1) begin
                    chk("opa_hold", OpA, cur_a);
                    chk("opb_hold", OpB, cur_b);
                end
            end
        end
    end

    // Called on a falling edge; returns on a falling edge with Ready high.
    task automatic wait_ready(input bit junk);
        int n = 0;
        while (Ready !== 1'b1 && n < 100) begin
            if (junk) begin
                OpValid = 1'b1; OpCode = 2'($urandom); RsVal = $urandom; RtVal = $urandom;
            end else begin
                OpValid = 1'b0;
            end
            @(negedge Clock);
            n++;
        end
        OpValid = 1'b0;
        if (Ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL ready_wait: got Ready=%b expected 1 within 100 cycles", Ready);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input bit junk);
        exp_t e;
        logic [63:0] r;
        int acc;
        acc = cyc + 1;
        e.kind = K_DONE;
        e.cyc = acc;
        case (op)
            OP_MULT: begin
                exp_mst++; m_lat = lat; r = mul64(a, b);
                if (lat <= TIMEOUT - 1) begin
                    e.cyc = acc + lat + 2; mdl_hi = r[63:32]; mdl_lo = r[31:0];
                end else begin
                    e.kind = K_TO; e.cyc = acc + 1 + TIMEOUT;
                end
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    e.kind = K_DZ;
                end else begin
                    exp_dst++; d_lat = lat; r = div64(a, b);
                    if (lat <= TIMEOUT - 1) begin
                        e.cyc = acc + lat + 2; mdl_hi = r[63:32]; mdl_lo = r[31:0];
                    end else begin
                        e.kind = K_TO; e.cyc = acc + 1 + TIMEOUT;
                    end
                end
            end
            OP_MTHI: mdl_hi = a;
            default: mdl_lo = a;
        endcase
        e.hi = mdl_hi; e.lo = mdl_lo; e.mst = exp_mst; e.dst = exp_dst;
        busy_lo = acc;
        busy_hi = (e.kind == K_TO) ? e.cyc : e.cyc + 1;
        cur_a = a; cur_b = b;
        sbq.push_back(e);
        OpValid = 1'b1; OpCode = op; RsVal = a; RtVal = b;
        @(posedge Clock);
        @(negedge Clock);
        wait_ready(junk);
    endtask

    // DIV abandoned by Reset on its tenth WAIT cycle; its late DivStop must be ignored.
    task automatic reset_mid_div();
        int acc;
        acc = cyc + 1;
        exp_dst++; d_lat = 20;
        cur_a = 32'd1000; cur_b = 32'd7;
        busy_lo = acc; busy_hi = acc + 11;
        OpValid = 1'b1; OpCode = OP_DIV; RsVal = 32'd1000; RtVal = 32'd7;
        @(posedge Clock);
        @(negedge Clock);
        OpValid = 1'b0;
        while (cyc < acc + 10) @(negedge Clock);
        Reset = 1'b1;
        cur_hi = 32'd0; cur_lo = 32'd0; mdl_hi = 32'd0; mdl_lo = 32'd0;
        @(negedge Clock);
        Reset = 1'b0;
        chk("rst_mid_ready", Ready, 1'b1);
        chk("rst_mid_opa", OpA, 32'd0);
        chk("rst_mid_opb", OpB, 32'd0);
        chk("rst_mid_pulses", {MultStart, DivStart, Done, DivZero, Timeout}, 5'd0);
        repeat (15) @(negedge Clock);
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [1:0] op;
        logic [31:0] a, b;
        int lat;
        Reset = 1'b1; OpValid = 1'b0; OpCode = 2'b00; RsVal = 32'd0; RtVal = 32'd0;
        repeat (3) @(negedge Clock);
        chk("rst_ready", Ready, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_opa", OpA, 32'd0);
        chk("rst_opb", OpB, 32'd0);
        chk("rst_pulses", {MultStart, DivStart, Done, DivZero, Timeout}, 5'd0);
        mon_en = 1'b1;
        Reset = 1'b0;
        @(negedge Clock);

        issue(OP_MULT, 32'd7, 32'hFFFFFFFD, 32, 1'b0);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFEB);

        issue(OP_MTHI, 32'h12345678, 32'd0, 0, 1'b0);
        issue(OP_MTLO, 32'h9ABCDEF0, 32'd0, 0, 1'b0);
        issue(OP_DIV, 32'd55, 32'd0, 3, 1'b0);
        chk("divzero_hi_kept", HI, 32'h12345678);
        chk("divzero_lo_kept", LO, 32'h9ABCDEF0);

        issue(OP_MTHI, 32'hCAFEBABE, 32'd0, 0, 1'b0);
        issue(OP_MTLO, 32'h0000BEEF, 32'd0, 0, 1'b0);
        chk("mthi_hi", HI, 32'hCAFEBABE);
        chk("mtlo_lo", LO, 32'h0000BEEF);

        noise_en = 1'b1;
        issue(OP_MULT, 32'd5, 32'd6, 45, 1'b0);
        chk("timeout_hi_kept", HI, 32'hCAFEBABE);
        issue(OP_MULT, 32'hDEADBEEF, 32'h01234567, TIMEOUT - 1, 1'b0);
        issue(OP_DIV, 32'd100, 32'd9, TIMEOUT, 1'b0);
        issue(OP_DIV, 32'hFFFFFF9C, 32'd7, 0, 1'b0);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0);

        reset_mid_div();
        issue(OP_MULT, 32'd12, 32'd13, 20, 1'b1);

        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            lat = ($urandom_range(0, 7) == 0) ? 45 : $urandom_range(0, TIMEOUT - 1);
            issue(op, a, b, lat, $urandom_range(0, 1) == 1);
        end

        repeat (50) @(negedge Clock);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
